// File: rtl/uart_cmd_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_master_if
//  Description : Byte-stream (UART RX/TX) and register-bus signal bundle for
//                uart_cmd_master. Signal names are given from the point of
//                view of the command master (the "master" modport).
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_master_if;
    // RX byte stream (from UART receiver)
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    // TX byte stream (to UART transmitter)
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    // Register bus
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;

    modport master (
        input  rx_data_i, rx_valid_i,
        output rx_ready_o,
        output tx_data_o, tx_valid_o,
        input  tx_ready_i,
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );

    modport slave (
        output rx_data_i, rx_valid_i,
        input  rx_ready_o,
        input  tx_data_o, tx_valid_o,
        output tx_ready_i,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_master
//  Description : Parses 'W'/'R' request frames from a UART RX byte stream,
//                issues one 32-bit register-bus transaction per frame and
//                returns the response bytes on the TX byte stream.
//                Optional trailing XOR checksum byte per frame, enabled by
//                defining UART_CMD_MASTER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_master #(
    parameter logic [31:0] FRAME_TIMEOUT = 32'd1_000_000,
    parameter logic [31:0] BUS_TIMEOUT   = 32'd4096
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    uart_cmd_master_if.master  cmd_if,
    output logic               busy_o,
    output logic               timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_REQ  = 3'd4,
        S_WAIT = 3'd5,
        S_RESP = 3'd6
    } state_t;

    localparam logic [7:0] C_CMD_WR   = 8'h57;
    localparam logic [7:0] C_CMD_RD   = 8'h52;
    localparam logic [7:0] C_RSP_BAD  = 8'h3F;
    localparam logic [7:0] C_RSP_ERR  = 8'h45;
    localparam logic [7:0] C_RSP_OK   = 8'h4B;
    localparam logic [7:0] C_RSP_TMO  = 8'h54;

`ifdef UART_CMD_MASTER_CHECKSUM_EN
    localparam logic [7:0] C_RSP_CSUM = 8'h43;
    // Once address/data are complete the frame still owes its checksum byte.
    localparam state_t S_FIELDS_DONE = S_CSUM;
`else
    localparam state_t S_FIELDS_DONE = S_REQ;
`endif

    state_t      state_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  byte_cnt_q;   // bytes of the current 4-byte field received
    logic [31:0] cnt_q;        // shared idle / bus-wait counter, saturating
    logic [31:0] resp_q;       // response bytes, current byte in [7:0]
    logic [1:0]  resp_left_q;  // bytes still to send after the current one
    logic        rdy_en_q;     // keeps rx_ready low until out of reset
    logic        timeout_q;
`ifdef UART_CMD_MASTER_CHECKSUM_EN
    logic [7:0]  chk_q;        // running XOR of the frame bytes
`endif

    logic w_rx_open;
    logic w_rx_fire;
    logic w_tx_fire;
    logic w_frame_expire;
    logic w_bus_expire;
    logic w_last_byte;

    assign w_rx_open = rdy_en_q &&
                       ((state_q == S_IDLE) || (state_q == S_ADDR) ||
                        (state_q == S_DATA) || (state_q == S_CSUM));
    assign w_rx_fire = w_rx_open && cmd_if.rx_valid_i;
    assign w_tx_fire = (state_q == S_RESP) && cmd_if.tx_ready_i;
    // Expiry fires in the FRAME_TIMEOUT-th / BUS_TIMEOUT-th counted cycle.
    assign w_frame_expire = (FRAME_TIMEOUT != 32'd0) && (cnt_q >= (FRAME_TIMEOUT - 32'd1));
    assign w_bus_expire   = (BUS_TIMEOUT   != 32'd0) && (cnt_q >= (BUS_TIMEOUT   - 32'd1));
    assign w_last_byte    = (byte_cnt_q == 2'd3);

    assign cmd_if.rx_ready_o  = w_rx_open;
    assign cmd_if.tx_valid_o  = (state_q == S_RESP);
    assign cmd_if.tx_data_o   = resp_q[7:0];
    assign cmd_if.bus_req_o   = (state_q == S_REQ);
    assign cmd_if.bus_we_o    = we_q;
    assign cmd_if.bus_addr_o  = addr_q;
    assign cmd_if.bus_wdata_o = wdata_q;
    assign busy_o             = (state_q != S_IDLE);
    assign timeout_o          = timeout_q;

    // Frame parser, bus sequencer and response serializer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            byte_cnt_q  <= 2'd0;
            cnt_q       <= 32'd0;
            resp_q      <= 32'd0;
            resp_left_q <= 2'd0;
            rdy_en_q    <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef UART_CMD_MASTER_CHECKSUM_EN
            chk_q       <= 8'd0;
`endif
        end else begin
            rdy_en_q  <= 1'b1;
            timeout_q <= 1'b0;
            if (cnt_q != 32'hFFFF_FFFF) begin
                cnt_q <= cnt_q + 32'd1;
            end
            case (state_q)
                S_IDLE: begin
                    cnt_q      <= 32'd0;
                    byte_cnt_q <= 2'd0;
                    if (w_rx_fire) begin
                        if ((cmd_if.rx_data_i == C_CMD_WR) || (cmd_if.rx_data_i == C_CMD_RD)) begin
                            we_q    <= (cmd_if.rx_data_i == C_CMD_WR);
                            state_q <= S_ADDR;
`ifdef UART_CMD_MASTER_CHECKSUM_EN
                            chk_q   <= cmd_if.rx_data_i;
`endif
                        end else begin
                            resp_q      <= {24'd0, C_RSP_BAD};
                            resp_left_q <= 2'd0;
                            state_q     <= S_RESP;
                        end
                    end
                end
                S_ADDR, S_DATA: begin
                    if (w_rx_fire) begin
                        cnt_q      <= 32'd0;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef UART_CMD_MASTER_CHECKSUM_EN
                        chk_q      <= chk_q ^ cmd_if.rx_data_i;
`endif
                        if (state_q == S_ADDR) begin
                            addr_q <= {cmd_if.rx_data_i, addr_q[31:8]};
                            if (w_last_byte) begin
                                state_q <= we_q ? S_DATA : S_FIELDS_DONE;
                            end
                        end else begin
                            wdata_q <= {cmd_if.rx_data_i, wdata_q[31:8]};
                            if (w_last_byte) begin
                                state_q <= S_FIELDS_DONE;
                            end
                        end
                    end else if (w_frame_expire) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
`ifdef UART_CMD_MASTER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_rx_fire) begin
                        if (cmd_if.rx_data_i == chk_q) begin
                            state_q <= S_REQ;
                        end else begin
                            resp_q      <= {24'd0, C_RSP_CSUM};
                            resp_left_q <= 2'd0;
                            state_q     <= S_RESP;
                        end
                    end else if (w_frame_expire) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
`endif
                S_REQ: begin
                    cnt_q <= 32'd0;
                    if (cmd_if.bus_gnt_i) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response landing in the expiry cycle still wins.
                    if (cmd_if.bus_rvalid_i) begin
                        state_q <= S_RESP;
                        if (cmd_if.bus_err_i) begin
                            resp_q      <= {24'd0, C_RSP_ERR};
                            resp_left_q <= 2'd0;
                        end else if (we_q) begin
                            resp_q      <= {24'd0, C_RSP_OK};
                            resp_left_q <= 2'd0;
                        end else begin
                            resp_q      <= cmd_if.bus_rdata_i;
                            resp_left_q <= 2'd3;
                        end
                    end else if (w_bus_expire) begin
                        timeout_q   <= 1'b1;
                        resp_q      <= {24'd0, C_RSP_TMO};
                        resp_left_q <= 2'd0;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_tx_fire) begin
                        if (resp_left_q == 2'd0) begin
                            state_q <= S_IDLE;
                        end else begin
                            resp_q      <= {8'd0, resp_q[31:8]};
                            resp_left_q <= resp_left_q - 2'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
